mem_burst_ctrl: RTL and testbench

MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

---
 rtl/mem_burst_ctrl_if.sv | 41 ++++
 rtl/mem_burst_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_burst_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_ctrl_if.sv
// Command, memory and status bundle for the burst fill/verify controller.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready handshake; the memory side has no stall.
// Ports: cmd_* (command in), mem_* (memory access out, read data in),
//        busy/done/err_count/first_err_addr (status out).
interface mem_burst_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [DATA_W-1:0] cmd_seed;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_write;
  logic              mem_enable;

  logic              busy;
  logic              done;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] first_err_addr;

  // Command source and memory model side.
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_seed, mem_data_out,
    input  cmd_ready, mem_address, mem_data_in, mem_write, mem_enable,
           busy, done, err_count, first_err_addr
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_seed, mem_data_out,
    output cmd_ready, mem_address, mem_data_in, mem_write, mem_enable,
           busy, done, err_count, first_err_addr
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst memory fill (write seed+i) / verify (read and compare against seed+i).
// Latency: fill of N beats -> done N+1 cycles after accept; verify -> N+2.
// Backpressure: cmd_ready only while idle; cmd_valid is ignored while busy.
// Ports: clock, reset_n (async active-low), bus (slave side of mem_burst_ctrl_if).
module mem_burst_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_burst_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] len_q;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W-1:0] beat;

  // Expected pattern travels alongside the read it belongs to, then one more
  // stage to line up with mem_data_out arriving a clock after the read.
  logic [DATA_W-1:0] exp_q;
  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;

  logic              accept;
  logic              last_beat;
  logic              issuing;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] beat_pat;

  assign accept    = bus.cmd_valid & bus.cmd_ready;
  assign last_beat = (beat == len_q);
  assign issuing   = (state == WRITE) || (state == READ);
  assign beat_addr = addr_q + beat;
  assign beat_pat  = seed_q + DATA_W'(beat);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.cmd_op ? READ : WRITE;
      WRITE:   if (last_beat) state_nxt = DONE;
      READ:    if (last_beat) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All visible outputs are registered. The access registers are loaded from
  // the current state, so beat i appears i+1 edges after acceptance and the
  // done flag appears one edge after the FSM sits in DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q             <= '0;
      len_q              <= '0;
      seed_q             <= '0;
      beat               <= '0;
      exp_q              <= '0;
      cmp_vld            <= 1'b0;
      cmp_exp            <= '0;
      cmp_addr           <= '0;
      bus.cmd_ready      <= 1'b1;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.mem_enable     <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_data_in    <= '0;
      bus.err_count      <= '0;
      bus.first_err_addr <= '0;
    end else begin
      // Ready only if idle now and staying idle; this keeps ready low during
      // the done cycle so the next accept lands on the edge after done falls.
      bus.cmd_ready <= (state == IDLE) && (state_nxt == IDLE);
      bus.busy      <= !((state == IDLE) && (state_nxt == IDLE));
      bus.done      <= (state == DONE);

      bus.mem_enable  <= issuing;
      bus.mem_write   <= (state == WRITE);
      bus.mem_address <= issuing ? beat_addr : '0;
      bus.mem_data_in <= (state == WRITE) ? beat_pat : '0;
      exp_q           <= (state == READ) ? beat_pat : '0;

      cmp_vld  <= bus.mem_enable & ~bus.mem_write;
      cmp_exp  <= exp_q;
      cmp_addr <= bus.mem_address;

      if (issuing) beat <= beat + 1'b1;

      // At most 2^ADDR_W beats per command, so the ADDR_W+1 bit counter
      // cannot wrap.
      if (cmp_vld && (bus.mem_data_out != cmp_exp)) begin
        bus.err_count <= bus.err_count + 1'b1;
        if (bus.err_count == '0) bus.first_err_addr <= cmp_addr;
      end

      // The last compare of a verify lands on the done edge, well before the
      // earliest possible next accept, so this override never drops a count.
      if (accept) begin
        addr_q             <= bus.cmd_addr;
        len_q              <= bus.cmd_len;
        seed_q             <= bus.cmd_seed;
        beat               <= '0;
        bus.err_count      <= '0;
        bus.first_err_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;

  logic clock = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_accept = 0;
  int   n_abort = 0;
  int   n_retired = 0;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } acc_t;

  typedef struct {
    logic [8:0] errs;
    logic [7:0] first;
    int         lat;
    int         acc_cyc;
  } done_t;

  acc_t  exp_acc[$];
  done_t exp_done[$];

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  mem_burst_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_burst_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous memory: read data is valid one clock after the read.
  always @(posedge clock) begin
    if (bus.mem_enable) begin
      if (bus.mem_write) mem[bus.mem_address] <= bus.mem_data_in;
      else               bus.mem_data_out     <= mem[bus.mem_address];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows an access or a done.
  always @(negedge clock) begin
    acc_t  a;
    done_t d;
    chk("busy", {31'd0, bus.busy}, {31'd0, n_accept > n_retired + n_abort});
    chk("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, !(n_accept > n_retired + n_abort)});
    if (bus.mem_enable) begin
      if (exp_acc.size() == 0) begin
        chk("unexpected_access", {31'd0, bus.mem_enable}, 32'd0);
      end else begin
        a = exp_acc.pop_front();
        chk("acc_write", {31'd0, bus.mem_write}, {31'd0, a.wr});
        chk("acc_addr", {24'd0, bus.mem_address}, {24'd0, a.addr});
        chk("acc_data", {24'd0, bus.mem_data_in}, {24'd0, a.data});
        chk("acc_cycle", cyc, a.cyc);
      end
    end
    if (bus.done) begin
      if (exp_done.size() == 0) begin
        chk("unexpected_done", {31'd0, bus.done}, 32'd0);
      end else begin
        d = exp_done.pop_front();
        chk("err_count", {23'd0, bus.err_count}, {23'd0, d.errs});
        chk("first_err_addr", {24'd0, bus.first_err_addr}, {24'd0, d.first});
        chk("latency", cyc - d.acc_cyc, d.lat);
      end
      n_retired++;
    end
  end

  // Issue one command from a negedge. The reference model walks beats
  // 0..len with plain modular arithmetic against ref_mem. abort_at >= 0
  // means a reset will kill the burst before beat abort_at reaches memory.
  task automatic send(input logic op, input logic [7:0] a, input logic [7:0] l,
                      input logic [7:0] s, input int abort_at, input bit hammer);
    int         t;
    int         c;
    bit         got_done;
    logic [8:0] errs;
    logic [7:0] first;
    acc_t       e;
    done_t      d;
    t = 0;
    while (!bus.cmd_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!bus.cmd_ready) begin
      chk("ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
      return;
    end
    c     = cyc + 1;
    errs  = '0;
    first = '0;
    for (int i = 0; i <= int'(l); i++) begin
      logic [7:0] ad;
      logic [7:0] p;
      ad = a + 8'(i);
      p  = s + 8'(i);
      if (abort_at < 0 || i < abort_at) begin
        e.wr   = !op;
        e.addr = ad;
        e.data = op ? 8'h00 : p;
        e.cyc  = c + 1 + i;
        exp_acc.push_back(e);
        if (!op) ref_mem[ad] = p;
      end
      if (op && ref_mem[ad] != p) begin
        if (errs == 0) first = ad;
        errs++;
      end
    end
    if (abort_at < 0) begin
      d.errs    = errs;
      d.first   = first;
      d.lat     = int'(l) + 1 + (op ? 2 : 1);
      d.acc_cyc = c;
      exp_done.push_back(d);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_seed  = s;
    @(posedge clock);
    #1;
    n_accept++;
    bus.cmd_valid = 1'b0;
    if (abort_at >= 0) return;
    got_done = 1'b0;
    t = 0;
    while (t < 700) begin
      @(negedge clock);
      t++;
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      // Offer junk while busy; it must never be accepted or queued.
      if (hammer) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'($urandom);
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_len   = 8'($urandom);
        bus.cmd_seed  = 8'($urandom);
      end
    end
    bus.cmd_valid = 1'b0;
    if (!got_done) chk("done_timeout", {31'd0, bus.done}, 32'd1);
  endtask

  initial begin
    logic       op;
    logic [7:0] a;
    logic [7:0] l;
    logic [7:0] s;
    logic [7:0] fa;
    logic [7:0] fl;
    logic [7:0] fs;

    reset_n       = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_seed  = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     <= 8'(i * 37 + 5);
      ref_mem[i]  = 8'(i * 37 + 5);
    end
    #2 reset_n = 1'b0;

    // Reset state.
    @(negedge clock);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_mem_enable", {31'd0, bus.mem_enable}, 32'd0);
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_mem_address", {24'd0, bus.mem_address}, 32'd0);
    chk("rst_mem_data_in", {24'd0, bus.mem_data_in}, 32'd0);
    chk("rst_err_count", {23'd0, bus.err_count}, 32'd0);
    chk("rst_first_err_addr", {24'd0, bus.first_err_addr}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Fill, verify clean, corrupt one byte, verify again.
    send(1'b0, 8'h10, 8'd3, 8'hA0, -1, 1'b0);
    send(1'b1, 8'h10, 8'd3, 8'hA0, -1, 1'b1);
    send(1'b0, 8'h12, 8'd0, 8'h00, -1, 1'b0);
    send(1'b1, 8'h10, 8'd3, 8'hA0, -1, 1'b0);
    @(negedge clock);
    chk("hold_err_count", {23'd0, bus.err_count}, 32'd1);
    chk("hold_first_err_addr", {24'd0, bus.first_err_addr}, 32'h12);
    chk("ready_after_done", {31'd0, bus.cmd_ready}, 32'd1);

    // Address and data wrap.
    send(1'b0, 8'hFE, 8'd2, 8'hFF, -1, 1'b0);
    chk("wrap_mem_fe", {24'd0, mem[8'hFE]}, 32'hFF);
    chk("wrap_mem_ff", {24'd0, mem[8'hFF]}, 32'h00);
    chk("wrap_mem_00", {24'd0, mem[8'h00]}, 32'h01);

    // Full-length verify with every beat mismatching.
    send(1'b0, 8'h00, 8'hFF, 8'h00, -1, 1'b0);
    send(1'b1, 8'h00, 8'hFF, 8'h01, -1, 1'b1);

    // Reset while beat 2 of a 10-beat fill is on the bus.
    send(1'b0, 8'h40, 8'd9, 8'h33, 2, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    n_abort++;
    #1;
    chk("abort_mem_enable", {31'd0, bus.mem_enable}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    repeat (15) @(negedge clock);
    for (int i = 0; i < 10; i++)
      chk("abort_mem_region", {24'd0, mem[8'(8'h40 + i)]}, {24'd0, ref_mem[8'(8'h40 + i)]});

    // Randomized commands; some verifies re-check the last fill.
    fa = 8'h00;
    fl = 8'h00;
    fs = 8'h00;
    repeat (40) begin
      op = 1'($urandom);
      a  = 8'($urandom);
      s  = 8'($urandom);
      l  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      if (op && $urandom_range(0, 1) == 1) begin
        a = fa;
        l = fl;
        s = fs;
      end
      if (!op) begin
        fa = a;
        fl = l;
        fs = s;
      end
      send(op, a, l, s, -1, 1'($urandom));
    end

    repeat (5) @(negedge clock);
    chk("leftover_accesses", exp_acc.size(), 32'd0);
    chk("leftover_dones", exp_done.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
